// File: rtl/alu_pkg.sv
// alu_pkg: shared constants and types for the ALU issue controller.
//   - 3-bit ALU operation codes driven to the external ALU
//   - instruction opcode / R-type funct field encodings
//   - FSM state type and branch-kind type
package alu_pkg;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_AND  = 3'b010;
  localparam logic [2:0] ALU_OR   = 3'b011;
  localparam logic [2:0] ALU_SLTU = 3'b100;
  localparam logic [2:0] ALU_SLT  = 3'b101;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    BR_NONE = 2'd0,
    BR_EQ   = 2'd1,
    BR_NE   = 2'd2
  } br_kind_t;

endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational instruction decode.
//   in : op[5:0], funct[5:0], imm[15:0], src_a, src_b
//   out: aluop[2:0], rega, regb (ALU operands), illegal, br_kind
// Unknown op/funct combinations decode as illegal with a zeroed ADD so the
// external ALU produces a harmless all-zero result.
module alu_decode
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [2:0]        aluop,
  output logic [DATA_W-1:0] rega,
  output logic [DATA_W-1:0] regb,
  output logic              illegal,
  output br_kind_t          br_kind
);

  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;

  assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_zext = {{(DATA_W-16){1'b0}}, imm};

  always_comb begin
    aluop   = ALU_ADD;
    rega    = src_a;
    regb    = src_b;
    illegal = 1'b0;
    br_kind = BR_NONE;
    case (op)
      OP_RTYPE: begin
        case (funct)
          FN_ADD:  aluop = ALU_ADD;
          FN_SUB:  aluop = ALU_SUB;
          FN_AND:  aluop = ALU_AND;
          FN_OR:   aluop = ALU_OR;
          FN_SLTU: aluop = ALU_SLTU;
          FN_SLT:  aluop = ALU_SLT;
          default: illegal = 1'b1;
        endcase
      end
      OP_ADDI:  begin aluop = ALU_ADD;  regb = imm_sext; end
      OP_SLTI:  begin aluop = ALU_SLT;  regb = imm_sext; end
      OP_SLTIU: begin aluop = ALU_SLTU; regb = imm_sext; end
      OP_ANDI:  begin aluop = ALU_AND;  regb = imm_zext; end
      OP_ORI:   begin aluop = ALU_OR;   regb = imm_zext; end
      OP_BEQ:   begin aluop = ALU_SUB;  br_kind = BR_EQ; end
      OP_BNE:   begin aluop = ALU_SUB;  br_kind = BR_NE; end
      default:  illegal = 1'b1;
    endcase
    if (illegal) begin
      aluop = ALU_ADD;
      rega  = '0;
      regb  = '0;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: decode, sequence and capture for an external combinational ALU.
//   CLK, Reset (async, active-high)
//   in_valid/in_ready      : request handshake (ready only in IDLE)
//   op, funct, imm, src_a, src_b : instruction fields and operands
//   ALUopcode, rega, regb  : registered drive to the external ALU
//   result, zero, sign     : external ALU response, same cycle
//   out_valid/out_ready    : result handshake (valid only in HOLD)
//   out_result, out_zero, out_sign, branch_taken, illegal, overflow
// Optional feature: define ALU_OVF_DETECT_EN to enable signed-overflow
// detection; otherwise overflow is tied to 0.
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        op,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  output logic [2:0]        ALUopcode,
  output logic [DATA_W-1:0] rega,
  output logic [DATA_W-1:0] regb,
  input  logic [DATA_W-1:0] result,
  input  logic              zero,
  input  logic              sign,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic              out_zero,
  output logic              out_sign,
  output logic              branch_taken,
  output logic              illegal,
  output logic              overflow
);

  state_t            state, state_nx;

  logic [2:0]        dec_aluop;
  logic [DATA_W-1:0] dec_rega, dec_regb;
  logic              dec_illegal;
  br_kind_t          dec_br;

  logic [2:0]        aluop_p0;
  logic [DATA_W-1:0] rega_p0, regb_p0;
  logic              illegal_p0;
  br_kind_t          br_p0;

  logic [DATA_W-1:0] result_p1;
  logic              zero_p1, sign_p1, taken_p1, illegal_p1;

`ifdef ALU_OVF_DETECT_EN
  logic              ovf_p1;

  // Signed overflow only exists for add/sub; the operand and result sign
  // bits are enough to detect it.
  function automatic logic ovf_detect(input logic [2:0] aop,
                                      input logic signed [DATA_W-1:0] a,
                                      input logic signed [DATA_W-1:0] b,
                                      input logic signed [DATA_W-1:0] r);
    case (aop)
      ALU_ADD: return (a[DATA_W-1] == b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      ALU_SUB: return (a[DATA_W-1] != b[DATA_W-1]) && (r[DATA_W-1] != a[DATA_W-1]);
      default: return 1'b0;
    endcase
  endfunction
`endif

  alu_decode #(.DATA_W(DATA_W)) u_decode (
    .op      (op),
    .funct   (funct),
    .imm     (imm),
    .src_a   (src_a),
    .src_b   (src_b),
    .aluop   (dec_aluop),
    .rega    (dec_rega),
    .regb    (dec_regb),
    .illegal (dec_illegal),
    .br_kind (dec_br)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (in_valid)  state_nx = ST_EXEC;
      ST_EXEC: state_nx = ST_HOLD;
      ST_HOLD: if (out_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state      <= ST_IDLE;
      aluop_p0   <= '0;
      rega_p0    <= '0;
      regb_p0    <= '0;
      illegal_p0 <= 1'b0;
      br_p0      <= BR_NONE;
      result_p1  <= '0;
      zero_p1    <= 1'b0;
      sign_p1    <= 1'b0;
      taken_p1   <= 1'b0;
      illegal_p1 <= 1'b0;
`ifdef ALU_OVF_DETECT_EN
      ovf_p1     <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      // Stage p0: decoded request registered on accept; drives the ALU.
      if (state == ST_IDLE && in_valid) begin
        aluop_p0   <= dec_aluop;
        rega_p0    <= dec_rega;
        regb_p0    <= dec_regb;
        illegal_p0 <= dec_illegal;
        br_p0      <= dec_br;
      end
      // Stage p1: ALU response and derived flags captured for the HOLD phase.
      if (state == ST_EXEC) begin
        result_p1  <= illegal_p0 ? '0 : result;
        zero_p1    <= zero;
        sign_p1    <= sign;
        taken_p1   <= (br_p0 == BR_EQ) ? zero : ((br_p0 == BR_NE) ? !zero : 1'b0);
        illegal_p1 <= illegal_p0;
`ifdef ALU_OVF_DETECT_EN
        ovf_p1     <= ovf_detect(aluop_p0, rega_p0, regb_p0, result);
`endif
      end
    end
  end

  assign in_ready     = (state == ST_IDLE);
  assign out_valid    = (state == ST_HOLD);
  assign ALUopcode    = aluop_p0;
  assign rega         = rega_p0;
  assign regb         = regb_p0;
  assign out_result   = result_p1;
  assign out_zero     = zero_p1;
  assign out_sign     = sign_p1;
  assign branch_taken = taken_p1;
  assign illegal      = illegal_p1;
`ifdef ALU_OVF_DETECT_EN
  assign overflow     = ovf_p1;
`else
  assign overflow     = 1'b0;
`endif

endmodule
